// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a_in - b_in LSB-first, one bit per enabled cycle,
// with valid/ready handshakes on both sides and a global enable that freezes all state.
module serial_subtractor #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ebl,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] a_in,
   input  logic [DATA_WIDTH-1:0] b_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] diff,
   output logic                  borrow_out,
   output logic                  busy
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                state_reg;
   logic [DATA_WIDTH-1:0] sa_reg;
   logic [DATA_WIDTH-1:0] sb_reg;
   logic [DATA_WIDTH-1:0] acc_reg;
   logic [DATA_WIDTH-1:0] diff_reg;
   logic [CW-1:0]         cnt_reg;
   logic                  br_reg;
   logic                  borrow_reg;
   logic                  out_valid_reg;
   logic                  busy_reg;

   logic                  d_bit;
   logic                  br_next;
   logic [DATA_WIDTH-1:0] acc_next;

   // One full-subtractor cell applied to the current LSBs of the shifting operands.
   assign d_bit    = sa_reg[0] ^ sb_reg[0] ^ br_reg;
   assign br_next  = (~sa_reg[0] & sb_reg[0]) | (~(sa_reg[0] ^ sb_reg[0]) & br_reg);
   assign acc_next = {d_bit, acc_reg[DATA_WIDTH-1:1]};

   assign in_ready   = (state_reg == IDLE) && ebl;
   assign out_valid  = out_valid_reg;
   assign diff       = diff_reg;
   assign borrow_out = borrow_reg;
   assign busy       = busy_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         sa_reg        <= '0;
         sb_reg        <= '0;
         acc_reg       <= '0;
         diff_reg      <= '0;
         cnt_reg       <= '0;
         br_reg        <= 1'b0;
         borrow_reg    <= 1'b0;
         out_valid_reg <= 1'b0;
         busy_reg      <= 1'b0;
      end else if (ebl) begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  sa_reg    <= a_in;
                  sb_reg    <= b_in;
                  br_reg    <= 1'b0;
                  cnt_reg   <= '0;
                  acc_reg   <= '0;
                  busy_reg  <= 1'b1;
                  state_reg <= RUN;
               end
            end
            RUN: begin
               br_reg  <= br_next;
               acc_reg <= acc_next;
               sa_reg  <= sa_reg >> 1;
               sb_reg  <= sb_reg >> 1;
               cnt_reg <= cnt_reg + 1'b1;
               // Publish only the finished word so diff never exposes partial bits.
               if (cnt_reg == LAST_BIT) begin
                  diff_reg      <= acc_next;
                  borrow_reg    <= br_next;
                  out_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  busy_reg      <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               out_valid_reg <= 1'b0;
               busy_reg      <= 1'b0;
               state_reg     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vectors with literal expectations plus a
// cycle-count scoreboard model compared against the DUT on every falling edge.
module tb_serial_subtractor;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         ebl = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a_in = '0;
   logic [W-1:0] b_in = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] diff;
   logic         borrow_out;
   logic         busy;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   bit chk_en = 1'b0;
   int acc_q[$];

   serial_subtractor #(.DATA_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .ebl(ebl),
      .in_valid(in_valid), .in_ready(in_ready),
      .a_in(a_in), .b_in(b_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .borrow_out(borrow_out), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (!rst && in_valid && in_ready) acc_q.push_back(cyc);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: an operation is pending for W enabled cycles, then holds its arithmetic result.
   bit           m_pending;
   int           m_rem;
   logic [W-1:0] m_a, m_b, m_diff;
   logic         m_borrow;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pending <= 1'b0;
         m_rem     <= 0;
         m_diff    <= '0;
         m_borrow  <= 1'b0;
      end else if (ebl) begin
         if (!m_pending) begin
            if (in_valid) begin
               m_pending <= 1'b1;
               m_rem     <= W;
               m_a       <= a_in;
               m_b       <= b_in;
            end
         end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
               m_diff   <= W'(m_a - m_b);
               m_borrow <= (m_a < m_b);
            end
         end else if (out_ready) begin
            m_pending <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmp_out_valid", out_valid, m_pending && (m_rem == 0));
         chk("cmp_busy", busy, m_pending);
         chk("cmp_in_ready", in_ready, !m_pending && ebl);
         chk("cmp_diff", diff, m_diff);
         chk("cmp_borrow", borrow_out, m_borrow);
      end
   end

   task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ed, input logic eb, input int elat,
                        input bit stall, input int hold);
      int t0;
      int n;
      @(posedge clk); #1;
      a_in = a; b_in = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      t0 = cyc;
      chk({name, "_busy_after_accept"}, busy, 1);
      if (stall) begin
         repeat (4) @(posedge clk);
         #1 ebl = 1'b0;
         repeat (3) @(posedge clk);
         #1 ebl = 1'b1;
      end
      n = 0;
      while (!out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_timeout"}, out_valid, 1);
      chk({name, "_latency"}, cyc - t0, elat);
      chk({name, "_diff"}, diff, ed);
      chk({name, "_borrow"}, borrow_out, eb);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({name, "_hold_valid"}, out_valid, 1);
         chk({name, "_hold_diff"}, diff, ed);
         chk({name, "_hold_in_ready"}, in_ready, 0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk({name, "_idle_in_ready"}, in_ready, 1);
      chk({name, "_idle_valid"}, out_valid, 0);
      chk({name, "_kept_diff"}, diff, ed);
      $display("[TB] op %s a=0x%04h b=0x%04h diff=0x%04h borrow=%0d", name, a, b, diff, borrow_out);
   endtask

   initial begin
      int n;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_diff", diff, 0);
      chk("reset_borrow", borrow_out, 0);
      chk("reset_busy", busy, 0);
      chk("reset_in_ready", in_ready, 1);
      chk_en = 1'b1;

      do_op("basic", 16'h1234, 16'h0034, 16'h1200, 1'b0, 16, 1'b0, 0);
      do_op("under1", 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 16, 1'b0, 0);
      do_op("under2", 16'h8000, 16'hFFFF, 16'h8001, 1'b1, 16, 1'b0, 0);
      do_op("bkpress", 16'h00F0, 16'h000F, 16'h00E1, 1'b0, 16, 1'b0, 5);
      do_op("stall", 16'h00FF, 16'h0100, 16'hFFFF, 1'b1, 19, 1'b1, 0);

      // Enable low in IDLE: no acceptance, in_ready forced low.
      @(posedge clk); #1;
      ebl = 1'b0; in_valid = 1'b1; a_in = 16'h5555; b_in = 16'h1111;
      repeat (3) @(negedge clk);
      chk("ebl_idle_in_ready", in_ready, 0);
      chk("ebl_idle_busy", busy, 0);
      @(posedge clk); #1;
      in_valid = 1'b0; ebl = 1'b1;

      // Back-to-back with both handshakes held high.
      @(posedge clk); #1;
      acc_q.delete();
      a_in = 16'hA5A5; b_in = 16'hA5A5; in_valid = 1'b1; out_ready = 1'b1;
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_diff", diff, 16'h0000);
      chk("b2b_borrow", borrow_out, 0);
      repeat (30) @(posedge clk);
      #1 in_valid = 1'b0;
      n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_drain", busy, 0);
      out_ready = 1'b0;
      chk("b2b_accepts", (acc_q.size() >= 2), 1);
      if (acc_q.size() >= 2) chk("b2b_spacing", acc_q[1] - acc_q[0], 18);
      $display("[TB] b2b accepts=%0d", acc_q.size());

      // Reset in the middle of RUN aborts the operation.
      @(posedge clk); #1;
      a_in = 16'h0F0F; b_in = 16'h0101; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rst_mid_valid", out_valid, 0);
      chk("rst_mid_diff", diff, 0);
      chk("rst_mid_busy", busy, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      do_op("after_rst", 16'h0010, 16'h0003, 16'h000D, 1'b0, 16, 1'b0, 0);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
